// File: rtl/frv_rng_responder.sv
// rtl/frv_rng_responder.sv - RNG request/response responder with LFSR entropy pool and seed-health tracking
// Optional feature: define FRV_RNG_FREE_RUN_EN to let the LFSR step on every cycle it is not otherwise updated.
module frv_rng_responder #(
  parameter int unsigned SEED_COUNT = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        rng_req_valid,
  input  logic [2:0]  rng_req_op,
  input  logic [31:0] rng_req_data,
  output logic        rng_req_ready,
  output logic        rng_rsp_valid,
  output logic [2:0]  rng_rsp_status,
  output logic [31:0] rng_rsp_data,
  input  logic        rng_rsp_ready
);

  typedef enum logic [2:0] {
    HS_NO_INIT   = 3'd0,
    HS_HEALTHY   = 3'd1,
    HS_UNHEALTHY = 3'd2
  } hstate_e;

  localparam logic [2:0]  OP_SEED   = 3'b001;
  localparam logic [2:0]  OP_SAMP   = 3'b010;
  localparam logic [2:0]  OP_TEST   = 3'b100;
  localparam logic [3:0]  SEED_MAX  = 4'(SEED_COUNT);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;

  hstate_e     hstate_q, hstate_d;
  logic [3:0]  seed_cnt_q, seed_cnt_d;
  logic [31:0] last_seed_q, last_seed_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        accept;
  logic        seed_bad;
  logic [31:0] seed_mix;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Ready depends only on the response slot, so the slot can refill as it drains.
  assign rng_req_ready  = !rsp_valid_q || rng_rsp_ready;
  assign accept         = rng_req_valid && rng_req_ready;
  assign rng_rsp_valid  = rsp_valid_q;
  assign rng_rsp_status = rsp_status_q;
  assign rng_rsp_data   = rsp_data_q;

  // Next-state: response slot, health FSM, seed counter and LFSR pool.
  always_comb begin
    hstate_d     = hstate_q;
    seed_cnt_d   = seed_cnt_q;
    last_seed_d  = last_seed_q;
`ifdef FRV_RNG_FREE_RUN_EN
    lfsr_d       = lfsr_step(lfsr_q);
`else
    lfsr_d       = lfsr_q;
`endif
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    seed_bad     = (rng_req_data == 32'h0) || (rng_req_data == last_seed_q);
    seed_mix     = lfsr_step(lfsr_q ^ rng_req_data);

    if (rsp_valid_q && rng_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_status_d = hstate_q;
      rsp_data_d   = 32'h0;
      case (rng_req_op)
        OP_SEED: begin
          if (seed_bad) begin
            hstate_d   = HS_UNHEALTHY;
            seed_cnt_d = 4'd0;
          end else begin
            if (seed_cnt_q < SEED_MAX) begin
              seed_cnt_d = seed_cnt_q + 4'd1;
            end
            if (seed_cnt_d == SEED_MAX) begin
              hstate_d = HS_HEALTHY;
            end
          end
          // A zero pool would lock the LFSR, so it is forced back to the init value.
          lfsr_d       = (seed_mix == 32'h0) ? LFSR_INIT : seed_mix;
          last_seed_d  = rng_req_data;
          rsp_status_d = hstate_d;
        end
        OP_SAMP: begin
          if (hstate_q == HS_HEALTHY) begin
            rsp_data_d = lfsr_q;
            lfsr_d     = lfsr_step(lfsr_q);
          end
        end
        OP_TEST: begin
        end
        default: begin
        end
      endcase
    end
  end

  // State register; reset discards any pending response at once.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      hstate_q     <= HS_NO_INIT;
      seed_cnt_q   <= 4'd0;
      last_seed_q  <= 32'h0;
      lfsr_q       <= LFSR_INIT;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 3'd0;
      rsp_data_q   <= 32'h0;
    end else begin
      hstate_q     <= hstate_d;
      seed_cnt_q   <= seed_cnt_d;
      last_seed_q  <= last_seed_d;
      lfsr_q       <= lfsr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: doc/frv_rng_responder.md
# frv_rng_responder

RNG-side responder for the CPU random-number request/response interface. It accepts one-hot test/seed/sample requests from the core's RNG interface and keeps a 32-bit LFSR entropy pool with a seed-health tracker. Every accepted request produces exactly one response carrying a status code and data. It sits between the core's RNG port and the platform, as the functional RNG model for simulation and FPGA builds.

## Interface
- `SEED_COUNT`, default 4: consecutive healthy seeds required to reach HEALTHY (1..15).
- `g_clk` in 1: global clock, all state on rising edge.
- `g_reset` in 1: asynchronous, active-high reset.
- `rng_req_valid` in 1: request present.
- `rng_req_op` in 3: one-hot `{test, samp, seed}` (bit2 test, bit1 samp, bit0 seed).
- `rng_req_data` in 32: seed data (used by seed only).
- `rng_req_ready` out 1: responder accepts request this cycle.
- `rng_rsp_valid` out 1: response held valid.
- `rng_rsp_status` out 3: NO_INIT=3'd0, INIT_HEALTHY=3'd1, INIT_UNHEALTHY=3'd2.
- `rng_rsp_data` out 32: sample data, else 0.
- `rng_rsp_ready` in 1: core takes response.

## Operation
- Request accepted when `rng_req_valid && rng_req_ready`.
- `rng_req_ready = !rng_rsp_valid || rng_rsp_ready`. There is one response slot, and it can be reloaded in the same cycle it drains.
- Health state machine `hstate` has three states: NO_INIT, HEALTHY and UNHEALTHY. `seed_cnt` is 4 bits. `last_seed` is 32 bits.
- LFSR step is Galois right-shift: `next = {1'b0,s[31:1]} ^ (s[0] ? 32'h8020_0003 : 0)`.
- Seed op:
  - Bad seed (`data==0` or `data==last_seed`): hstate goes to UNHEALTHY and seed_cnt clears to 0.
  - Good seed: seed_cnt increments, saturating at SEED_COUNT. When it reaches SEED_COUNT, hstate goes to HEALTHY.
  - Every seed: the LFSR loads `step(lfsr ^ data)`. If the result is 0, it loads 32'h0000_0001 instead. `last_seed` is updated with `data`.
  - Response: status after the update, data 0.
- Sample op:
  - When HEALTHY: data = current LFSR value, then the LFSR steps once.
  - Otherwise: data 0 and the LFSR is unchanged.
  - Status is the current hstate.
- Test op: status = current hstate, data 0, no state change.
- Illegal op (zero or multi-hot): status = current hstate, data 0, no state change.
- From NO_INIT or UNHEALTHY, SEED_COUNT consecutive good seeds are needed before HEALTHY. A bad seed while HEALTHY drops to UNHEALTHY immediately.
- Responses are returned strictly in request order. A request is never dropped.

## Timing
- Reset values:
  - Outputs: `rng_rsp_valid`=0, `rng_rsp_status`=3'd0, `rng_rsp_data`=0, `rng_req_ready`=1.
  - Internal: hstate=NO_INIT, seed_cnt=0, last_seed=0, lfsr=32'h0000_0001.
- Latency: a request accepted at edge N gives `rng_rsp_valid` high after edge N, i.e. one cycle.
- `rng_rsp_valid`, `rng_rsp_status` and `rng_rsp_data` are registered. They are held stable until the cycle in which `rng_rsp_ready` is high.
- Throughput: with `rng_rsp_ready` held high, one request per cycle.
- Back-pressure: while `rng_rsp_valid && !rng_rsp_ready`, `rng_req_ready` is 0. Request fields are ignored and no state changes.
- Simultaneous drain and accept: the old response retires and the new response loads on the same edge, so `rng_rsp_valid` stays 1.
- Asserting `g_reset` at any time clears a pending response immediately (asynchronously) and discards it. The first request after deassertion sees NO_INIT.
- `rng_req_ready` is combinational from `rng_rsp_valid` and `rng_rsp_ready` only. There is no path from the request inputs.

## Configuration
- Macro `FRV_RNG_FREE_RUN_EN`.
- Defined: the LFSR also steps every cycle that no seed or sample updates it, including while NO_INIT or UNHEALTHY. Sample values depend on request timing.
- Undefined: the LFSR changes only on seed ops and healthy sample ops, so the sequence is fully deterministic from the seed history.
- Response format, handshake timing and the health state machine are identical in both builds.

## Test plan
- Reset, then test op → response one cycle later with status 3'd0 and data 0; `rng_req_ready` high throughout.
- Sample before seeding → status 3'd0, data 0; a following test op still returns 3'd0.
- Seeds 32'h1, 32'h2, 32'h3, 32'h4 (SEED_COUNT=4) → statuses 0,0,0,1; then a sample gives data equal to the model LFSR value (not 0) and status 1. Two back-to-back samples differ.
- From HEALTHY, seed 32'h4 again (repeat) → status 3'd2; a sample returns data 0 and status 2. Four new distinct nonzero seeds return to status 1 on the fourth.
- Seed 32'h0 → status 3'd2 and seed_cnt cleared; with seed data equal to the LFSR pre-state, LFSR load is 32'h1.
- Back-pressure: hold `rng_rsp_ready`=0 for 5 cycles with a response pending → data, status and valid stable and `rng_req_ready`=0. Release with a new request present → drain and accept on the same edge, valid stays 1. Assert `g_reset` mid-stall → `rng_rsp_valid` drops immediately.
